spi_packet_arbiter: RTL and testbench

//  N-input val/rdy arbiter in front of the SPI val/rdy wrapper. It multiplexes component responses onto one stream
//  and prepends the source index as an address header. Grants rotate round-robin, or fixed LSB-first if selected.
//  A grant is locked for a whole multi-beat packet, so Disassembler beats are never interleaved.

---
 rtl/spi_packet_arbiter_if.sv | 32 +++
 rtl/spi_packet_arbiter.sv | 126 ++++++++++++
 tb/tb_spi_packet_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/spi_packet_arbiter_if.sv
// Request/response bus between the SPI val/rdy wrapper side and the packet arbiter.
// The arbiter takes the slave modport; whoever drives requests and sinks responses takes master.
interface spi_packet_arbiter_if #(
    parameter int nbits      = 32,
    parameter int num_inputs = 6,
    parameter int addr_nbits = $clog2(num_inputs)
);
    logic [num_inputs-1:0]       req_val;
    logic [num_inputs-1:0]       req_rdy;
    logic [num_inputs*nbits-1:0] req_msg;
    logic                        resp_val;
    logic                        resp_rdy;
    logic [addr_nbits+nbits-1:0] resp_msg;

    modport master (
        output req_val,
        output req_msg,
        output resp_rdy,
        input  req_rdy,
        input  resp_val,
        input  resp_msg
    );

    modport slave (
        input  req_val,
        input  req_msg,
        input  resp_rdy,
        output req_rdy,
        output resp_val,
        output resp_msg
    );
endinterface

// File: rtl/spi_packet_arbiter.sv
// N-input val/rdy arbiter that tags each beat with its source index and keeps
// multi-beat packets contiguous by locking the grant for the whole packet.
module spi_packet_arbiter #(
    parameter int nbits      = 32,
    parameter int num_inputs = 6,
    parameter int addr_nbits = $clog2(num_inputs),
    parameter int pkt_beats  = 1,
    parameter int RR_MODE    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    spi_packet_arbiter_if.slave     bus,
    output logic                    busy
);

    localparam int CNT_W = $clog2(pkt_beats + 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(pkt_beats - 1);
    localparam logic [addr_nbits-1:0] PTR_INIT  = addr_nbits'(num_inputs - 1);

    logic [0:0]            state;
    logic [CNT_W-1:0]      beat_cnt;
    logic [addr_nbits-1:0] lock_idx;
    logic [addr_nbits-1:0] rr_ptr;

    logic [addr_nbits-1:0] grant;
    logic [num_inputs-1:0] rdy_vec;
    logic [nbits-1:0]      grant_payload;
    logic                  space;
    logic                  any_val;
    logic                  accept;
    logic                  resp_val_q;
    logic [addr_nbits+nbits-1:0] resp_msg_q;

    assign space   = !resp_val_q | bus.resp_rdy;
    assign any_val = |bus.req_val;
    assign busy    = (state == LOCKED);

    // Round-robin scans upward starting just after the last winner; fixed mode
    // always scans from index 0, so high indices may starve by design.
    always_comb begin
        logic found;
        int   idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        if (state == LOCKED) begin
            grant = lock_idx;
        end else if (RR_MODE != 0) begin
            for (int k = 1; k <= num_inputs; k++) begin
                idx = (int'(rr_ptr) + k) % num_inputs;
                if (!found && bus.req_val[idx]) begin
                    grant = addr_nbits'(idx);
                    found = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < num_inputs; i++) begin
                if (!found && bus.req_val[i]) begin
                    grant = addr_nbits'(i);
                    found = 1'b1;
                end
            end
        end
    end

    // Ready is withheld during reset so nothing can be handed over before the stage is clean.
    always_comb begin
        rdy_vec = '0;
        if (!reset) begin
            rdy_vec[grant] = space & ((state == LOCKED) | any_val);
        end
    end

    assign bus.req_rdy  = rdy_vec;
    assign accept       = bus.req_val[grant] & rdy_vec[grant];
    assign grant_payload = bus.req_msg[int'(grant)*nbits +: nbits];

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_val_q <= 1'b0;
            resp_msg_q <= '0;
        end else if (accept) begin
            resp_val_q <= 1'b1;
            resp_msg_q <= {grant, grant_payload};
        end else if (bus.resp_rdy) begin
            resp_val_q <= 1'b0;
        end
    end

    assign bus.resp_val = resp_val_q;
    assign bus.resp_msg = resp_msg_q;

    // rr_ptr only moves at packet boundaries, so a new winner is chosen from
    // the updated pointer on the cycle after the last beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            beat_cnt <= '0;
            lock_idx <= '0;
            rr_ptr   <= PTR_INIT;
        end else if (accept) begin
            if (state == IDLE) begin
                if (pkt_beats == 1) begin
                    rr_ptr <= grant;
                end else begin
                    state    <= LOCKED;
                    lock_idx <= grant;
                    beat_cnt <= CNT_W'(1);
                end
            end else begin
                if (beat_cnt == LAST_BEAT) begin
                    state    <= IDLE;
                    rr_ptr   <= lock_idx;
                    beat_cnt <= '0;
                end else begin
                    beat_cnt <= beat_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_packet_arbiter.sv
// Directed bench for spi_packet_arbiter: four instances cover round-robin single beats,
// locked 4-beat packets, a mid-packet request gap, and fixed priority with mid-packet reset.
module tb_spi_packet_arbiter;

    typedef struct {
        logic [5:0]  req_val;
        logic        resp_rdy;
        logic [5:0]  exp_rdy;
        logic        exp_val;
        logic [10:0] exp_msg;
        logic        exp_busy;
    } vec_t;

    localparam logic [47:0] MSGS = {8'hA5, 8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0};

    logic clk = 1'b0;
    logic reset_a, reset_b, reset_c, reset_d;
    logic busy_a, busy_b, busy_c, busy_d;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];

    spi_packet_arbiter_if #(.nbits(8), .num_inputs(6)) if_a ();
    spi_packet_arbiter_if #(.nbits(8), .num_inputs(6)) if_b ();
    spi_packet_arbiter_if #(.nbits(8), .num_inputs(6)) if_c ();
    spi_packet_arbiter_if #(.nbits(8), .num_inputs(6)) if_d ();

    spi_packet_arbiter #(.nbits(8), .num_inputs(6), .pkt_beats(1), .RR_MODE(1))
        dut_a (.clk(clk), .reset(reset_a), .bus(if_a.slave), .busy(busy_a));
    spi_packet_arbiter #(.nbits(8), .num_inputs(6), .pkt_beats(4), .RR_MODE(1))
        dut_b (.clk(clk), .reset(reset_b), .bus(if_b.slave), .busy(busy_b));
    spi_packet_arbiter #(.nbits(8), .num_inputs(6), .pkt_beats(3), .RR_MODE(1))
        dut_c (.clk(clk), .reset(reset_c), .bus(if_c.slave), .busy(busy_c));
    spi_packet_arbiter #(.nbits(8), .num_inputs(6), .pkt_beats(2), .RR_MODE(0))
        dut_d (.clk(clk), .reset(reset_d), .bus(if_d.slave), .busy(busy_d));

    always #5 clk = ~clk;

    function automatic logic [10:0] m(input int i);
        logic [2:0] h;
        logic [7:0] p;
        h = 3'(i);
        p = 8'(8'hA0 + i);
        return {h, p};
    endfunction

    function automatic vec_t mk(input logic [5:0] rv, input logic rr, input logic [5:0] erdy,
                                input logic ev, input logic [10:0] emsg, input logic eb);
        vec_t v;
        v.req_val  = rv;
        v.resp_rdy = rr;
        v.exp_rdy  = erdy;
        v.exp_val  = ev;
        v.exp_msg  = emsg;
        v.exp_busy = eb;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int inst, input logic [5:0] rv, input logic rr);
        case (inst)
            0: begin if_a.req_val = rv; if_a.resp_rdy = rr; end
            1: begin if_b.req_val = rv; if_b.resp_rdy = rr; end
            2: begin if_c.req_val = rv; if_c.resp_rdy = rr; end
            default: begin if_d.req_val = rv; if_d.resp_rdy = rr; end
        endcase
    endtask

    task automatic checkInst(input int inst, input string tag, input vec_t v);
        logic [5:0]  rdy;
        logic        val;
        logic [10:0] msg;
        logic        bsy;
        case (inst)
            0: begin rdy = if_a.req_rdy; val = if_a.resp_val; msg = if_a.resp_msg; bsy = busy_a; end
            1: begin rdy = if_b.req_rdy; val = if_b.resp_val; msg = if_b.resp_msg; bsy = busy_b; end
            2: begin rdy = if_c.req_rdy; val = if_c.resp_val; msg = if_c.resp_msg; bsy = busy_c; end
            default: begin rdy = if_d.req_rdy; val = if_d.resp_val; msg = if_d.resp_msg; bsy = busy_d; end
        endcase
        checkOutput({tag, " req_rdy"},  16'(rdy), 16'(v.exp_rdy));
        checkOutput({tag, " resp_val"}, 16'(val), 16'(v.exp_val));
        checkOutput({tag, " resp_msg"}, 16'(msg), 16'(v.exp_msg));
        checkOutput({tag, " busy"},     16'(bsy), 16'(v.exp_busy));
    endtask

    task automatic runTable(input int inst, input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            applyStimulus(inst, tbl[i].req_val, tbl[i].resp_rdy);
            #1;
            checkInst(inst, $sformatf("%s[%0d]", name, i), tbl[i]);
        end
        @(negedge clk);
        applyStimulus(inst, 6'h00, 1'b1);
    endtask

    initial begin
        vec_t v;
        reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1; reset_d = 1'b1;
        if_a.req_msg = MSGS; if_b.req_msg = MSGS; if_c.req_msg = MSGS; if_d.req_msg = MSGS;
        applyStimulus(0, 6'h3F, 1'b1);
        applyStimulus(1, 6'h00, 1'b1);
        applyStimulus(2, 6'h00, 1'b1);
        applyStimulus(3, 6'h00, 1'b1);

        // Reset held two cycles with every request raised: nothing may be offered.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            checkInst(0, $sformatf("reset[%0d]", c), mk(6'h00, 1'b1, 6'h00, 1'b0, 11'h000, 1'b0));
        end
        applyStimulus(0, 6'h00, 1'b1);
        reset_a = 1'b0; reset_b = 1'b0; reset_c = 1'b0; reset_d = 1'b0;

        // Round robin, single-beat packets, then backpressure and sparse requests.
        tbl.delete();
        tbl.push_back(mk(6'h3F, 1, 6'h01, 0, 11'h000, 0));
        tbl.push_back(mk(6'h3F, 1, 6'h02, 1, m(0), 0));
        tbl.push_back(mk(6'h3F, 1, 6'h04, 1, m(1), 0));
        tbl.push_back(mk(6'h3F, 1, 6'h08, 1, m(2), 0));
        tbl.push_back(mk(6'h3F, 1, 6'h10, 1, m(3), 0));
        tbl.push_back(mk(6'h3F, 1, 6'h20, 1, m(4), 0));
        tbl.push_back(mk(6'h3F, 1, 6'h01, 1, m(5), 0));
        tbl.push_back(mk(6'h3F, 1, 6'h02, 1, m(0), 0));
        tbl.push_back(mk(6'h3F, 0, 6'h00, 1, m(1), 0));
        tbl.push_back(mk(6'h3F, 0, 6'h00, 1, m(1), 0));
        tbl.push_back(mk(6'h3F, 1, 6'h04, 1, m(1), 0));
        tbl.push_back(mk(6'h00, 1, 6'h00, 1, m(2), 0));
        tbl.push_back(mk(6'h00, 1, 6'h00, 0, m(2), 0));
        tbl.push_back(mk(6'h01, 1, 6'h01, 0, m(2), 0));
        tbl.push_back(mk(6'h21, 1, 6'h20, 1, m(0), 0));
        tbl.push_back(mk(6'h21, 1, 6'h01, 1, m(5), 0));
        tbl.push_back(mk(6'h00, 1, 6'h00, 1, m(0), 0));
        tbl.push_back(mk(6'h00, 1, 6'h00, 0, m(0), 0));
        runTable(0, "rr");

        // Four-beat packets from inputs 1 and 3 must not interleave.
        tbl.delete();
        for (int k = 0; k < 8; k++) begin
            v = mk(6'h0A, 1, (k < 4) ? 6'h02 : 6'h08, (k > 0),
                   (k == 0) ? 11'h000 : m((k - 1 < 4) ? 1 : 3), ((k % 4) != 0));
            tbl.push_back(v);
        end
        tbl.push_back(mk(6'h00, 1, 6'h00, 1, m(3), 0));
        runTable(1, "lock");

        // Input 2 stalls mid-packet while input 0 waits; the lock must hold.
        tbl.delete();
        tbl.push_back(mk(6'h04, 1, 6'h04, 0, 11'h000, 0));
        tbl.push_back(mk(6'h01, 1, 6'h04, 1, m(2), 1));
        tbl.push_back(mk(6'h01, 1, 6'h04, 0, m(2), 1));
        tbl.push_back(mk(6'h05, 1, 6'h04, 0, m(2), 1));
        tbl.push_back(mk(6'h05, 1, 6'h04, 1, m(2), 1));
        tbl.push_back(mk(6'h05, 1, 6'h01, 1, m(2), 0));
        tbl.push_back(mk(6'h05, 1, 6'h01, 1, m(0), 1));
        tbl.push_back(mk(6'h00, 1, 6'h01, 1, m(0), 1));
        runTable(2, "gap");

        // Fixed priority: input 0 always wins over 5; then reset lands mid-packet.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            applyStimulus(3, 6'h21, 1'b1);
            #1;
            checkInst(3, $sformatf("fixed[%0d]", k),
                      mk(6'h21, 1, 6'h01, (k > 0), (k == 0) ? 11'h000 : m(0), ((k % 2) != 0)));
        end
        reset_d = 1'b1;
        @(negedge clk);
        #1;
        checkInst(3, "midreset", mk(6'h21, 1, 6'h00, 0, 11'h000, 0));
        reset_d = 1'b0;
        #1;
        checkInst(3, "postreset", mk(6'h21, 1, 6'h01, 0, 11'h000, 0));
        @(negedge clk);
        #1;
        checkInst(3, "firstbeat", mk(6'h21, 1, 6'h01, 1, m(0), 1));
        applyStimulus(3, 6'h00, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
